// File: rtl/hilo_pkg.sv
// Shared decode constants, FSM state encoding and multiply/divide op type for hilo_muldiv.
package hilo_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  function automatic md_op_e decode_md(input logic [31:0] instr);
    md_op_e op;
    op = MD_NONE;
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        F_MULT:  op = MD_MULT;
        F_MULTU: op = MD_MULTU;
        F_DIV:   op = MD_DIV;
        F_DIVU:  op = MD_DIVU;
        default: op = MD_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/hilo_muldiv_iter.sv
// Iterative datapath: 2W-bit shift register / accumulator, latched operand and step counter.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_o,
  output logic [W-1:0]   b_o,
  output logic           last_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     mul_sum, rem_sh, diff;
  logic           ge;
  logic [W-1:0]   rem_new;

  // Restoring step: the partial remainder stays below the divisor, so the top
  // bit of the trial difference is a borrow flag. With a zero divisor the low
  // W bits are the shifted remainder either way, leaving |dividend| in the top half.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    diff    = rem_sh - {1'b0, b_q};
    ge      = !diff[W];
    rem_new = ge ? diff[W-1:0] : rem_sh[W-1:0];

    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (start_i) begin
      acc_d = {{W{1'b0}}, a_i};
      b_d   = b_i;
      cnt_d = '0;
    end else if (step_i) begin
      acc_d = div_i ? {rem_new, acc_q[W-2:0], ge} : {mul_sum, acc_q[W-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign b_o    = b_q;
  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO. Optional MULT_FAST_EN: single-cycle MULT/MULTU.
//   state  | meaning
//   S_IDLE | no operation in flight; MTHI/MTLO and fast multiply write here
//   S_RUN  | one shift-add / restoring-divide iteration per cycle, pipeline stalled
//   S_FIX  | sign correction, HI/LO written at the end of the cycle
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int           W      = 32,
  parameter logic [W-1:0] DIV0_Q = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  instrE,
  input  logic         validE,
  input  logic         holdE,
  input  logic         flushE,
  input  logic [W-1:0] aluA,
  input  logic [W-1:0] aluB,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO,
  output logic         stall_o,
  output logic         busy_o
);

  state_e         state_q, state_d;
  md_op_e         op;
  logic           is_special, is_mthi, is_mtlo, is_hl, is_signed, iter_op;
  logic           issue, write_en, start, step, last;
  logic           done_q, done_d, sa_q, sb_q, div_q;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, b_lat, q_fix, r_fix;
  logic [2*W-1:0] acc, prod_fix;
  logic           unused_instr;

  assign op           = decode_md(instrE);
  assign is_special   = (instrE[31:26] == OP_SPECIAL);
  assign is_mthi      = is_special & (instrE[5:0] == F_MTHI);
  assign is_mtlo      = is_special & (instrE[5:0] == F_MTLO);
  assign is_hl        = is_mthi | is_mtlo | (is_special &
                        ((instrE[5:0] == F_MFHI) | (instrE[5:0] == F_MFLO)));
  assign is_signed    = (op == MD_MULT) | (op == MD_DIV);
  assign unused_instr = ^instrE[25:6];

`ifdef MULT_FAST_EN
  logic           fast_op;
  logic [2*W-1:0] ext_a, ext_b, fast_prod;
  assign iter_op   = (op == MD_DIV) | (op == MD_DIVU);
  assign fast_op   = (op == MD_MULT) | (op == MD_MULTU);
  assign ext_a     = is_signed ? {{W{aluA[W-1]}}, aluA} : {{W{1'b0}}, aluA};
  assign ext_b     = is_signed ? {{W{aluB[W-1]}}, aluB} : {{W{1'b0}}, aluB};
  assign fast_prod = ext_a * ext_b;
`else
  assign iter_op   = (op != MD_NONE);
`endif

  assign issue    = (state_q == S_IDLE) & validE & iter_op & !flushE & !done_q;
  assign busy_o   = (state_q != S_IDLE);
  assign stall_o  = !flushE & (issue | (state_q == S_RUN) | (validE & is_hl & busy_o));
  assign write_en = validE & !stall_o & !flushE & !holdE;
  assign a_mag    = (is_signed & aluA[W-1]) ? -aluA : aluA;
  assign b_mag    = (is_signed & aluB[W-1]) ? -aluB : aluB;

  hilo_iter_core #(.W(W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .step_i  (step),
    .div_i   (div_q),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .acc_o   (acc),
    .b_o     (b_lat),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: if (issue) begin
        start   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (flushE) begin
        state_d = S_IDLE;
      end else begin
        step = 1'b1;
        if (last) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc : acc;
    q_fix    = (sa_q ^ sb_q) ? -acc[W-1:0] : acc[W-1:0];
    if (b_lat == '0) q_fix = DIV0_Q;
    r_fix    = sa_q ? -acc[2*W-1:W] : acc[2*W-1:W];

    hi_d = hi_q;
    lo_d = lo_q;
    if ((state_q == S_FIX) && !flushE) begin
      if (div_q) begin
        hi_d = r_fix;
        lo_d = q_fix;
      end else begin
        {hi_d, lo_d} = prod_fix;
      end
    end else if (write_en & is_mthi) begin
      hi_d = aluA;
    end else if (write_en & is_mtlo) begin
      lo_d = aluA;
    end
`ifdef MULT_FAST_EN
    else if (write_en & fast_op) begin
      {hi_d, lo_d} = fast_prod;
    end
`endif

    // done only survives the FIX edge if the instruction is being held in EX
    done_d = done_q;
    if ((state_q == S_FIX) && !flushE) done_d = holdE;
    else if (!holdE || flushE)          done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (start) begin
        sa_q  <= is_signed & aluA[W-1];
        sb_q  <= is_signed & aluB[W-1];
        div_q <= (op == MD_DIV) | (op == MD_DIVU);
      end
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (default build, iterative multiply).
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instrE, aluA, aluB;
  logic        validE, holdE, flushE;
  logic [31:0] HI, LO;
  logic        stall_o, busy_o;

  localparam logic [31:0] I_MULT  = 32'h0085_0018;
  localparam logic [31:0] I_MULTU = 32'h0085_0019;
  localparam logic [31:0] I_DIV   = 32'h0085_001A;
  localparam logic [31:0] I_DIVU  = 32'h0085_001B;
  localparam logic [31:0] I_MTHI  = 32'h0080_0011;
  localparam logic [31:0] I_MTLO  = 32'h0080_0013;
  localparam logic [31:0] I_MFHI  = 32'h0000_1010;
  localparam logic [31:0] I_MFLO  = 32'h0000_1012;
  localparam logic [31:0] I_ADDI  = 32'h2000_0018;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .instrE  (instrE),
    .validE  (validE),
    .holdE   (holdE),
    .flushE  (flushE),
    .aluA    (aluA),
    .aluB    (aluB),
    .HI      (HI),
    .LO      (LO),
    .stall_o (stall_o),
    .busy_o  (busy_o)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    validE = 1'b0;
    instrE = 32'h0;
    holdE  = 1'b0;
    flushE = 1'b0;
  endtask

  // Drives the op at cycle 0 and counts stalled cycles; returns inside the first non-stalled cycle.
  task automatic issue_count(input logic [31:0] instr, input logic [31:0] a,
                             input logic [31:0] b, output int nstall);
    next_cyc();
    instrE = instr;
    aluA   = a;
    aluB   = b;
    validE = 1'b1;
    #2;
    nstall = 0;
    while (stall_o && nstall < 60) begin
      nstall++;
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen_busy, seen_stall;

    vecs[0]  = '{"mult -3*7",        I_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{"multu ffffffff*2", I_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{"div -7/2",         I_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu 7/0",         I_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4]  = '{"div min/-1",       I_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{"div 7/-2",         I_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6]  = '{"divu 100/7",       I_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[7]  = '{"div -7/0",         I_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{"multu 12345678*16",I_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[9]  = '{"mult min*min",     I_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[10] = '{"mult -1*-1",       I_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[11] = '{"divu ffffffff/16", I_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

    rst_n = 1'b0;
    aluA  = 32'h0;
    aluB  = 32'h0;
    idle_in();
    #12;
    chk("reset HI", HI, 32'h0);
    chk("reset LO", LO, 32'h0);
    chk("reset stall", {31'h0, stall_o}, 32'h0);
    chk("reset busy", {31'h0, busy_o}, 32'h0);
    next_cyc();
    rst_n = 1'b1;

    // Non-SPECIAL opcode with a multiply funct must not issue
    next_cyc();
    instrE = I_ADDI; validE = 1'b1; aluA = 32'h5; aluB = 32'h6;
    #2;
    chk("addi no stall", {31'h0, stall_o}, 32'h0);
    next_cyc();
    instrE = I_MFHI;
    #2;
    chk("addi no busy", {31'h0, busy_o}, 32'h0);
    chk("mfhi idle no stall", {31'h0, stall_o}, 32'h0);
    next_cyc();
    idle_in();

    for (int i = 0; i < 12; i++) begin
      issue_count(vecs[i].instr, vecs[i].a, vecs[i].b, n);
      chk({vecs[i].name, " stall cycles"}, 32'(n), 32'd33);
      chk({vecs[i].name, " busy in fix"}, {31'h0, busy_o}, 32'h1);
      next_cyc();
      idle_in();
      #2;
      chk({vecs[i].name, " HI"}, HI, vecs[i].hi);
      chk({vecs[i].name, " LO"}, LO, vecs[i].lo);
    end

    // mflo waiting behind a running multiply
    next_cyc();
    instrE = I_MULT; aluA = 32'h3; aluB = 32'h5; validE = 1'b1;
    #2;
    chk("mflo-wait issue stall", {31'h0, stall_o}, 32'h1);
    next_cyc();
    instrE = I_MFLO; aluA = 32'h0; aluB = 32'h0;
    #2;
    n = 1;
    while (stall_o && n < 60) begin
      n++;
      @(posedge clk);
      #3;
    end
    chk("mflo-wait stall cycles", 32'(n), 32'd34);
    chk("mflo-wait busy", {31'h0, busy_o}, 32'h0);
    chk("mflo-wait LO", LO, 32'h0000_000F);
    chk("mflo-wait HI", HI, 32'h0);
    next_cyc();
    idle_in();

    // MTHI/MTLO then back-to-back MFHI/MFLO; flushed MTLO must not write
    next_cyc();
    instrE = I_MTHI; aluA = 32'h1234_5678; validE = 1'b1;
    #2;
    chk("mthi no stall", {31'h0, stall_o}, 32'h0);
    next_cyc();
    instrE = I_MFHI; aluA = 32'h0;
    #2;
    chk("mthi->mfhi HI", HI, 32'h1234_5678);
    next_cyc();
    instrE = I_MTLO; aluA = 32'h9ABC_DEF0;
    next_cyc();
    instrE = I_MFLO; aluA = 32'h0;
    #2;
    chk("mtlo->mflo LO", LO, 32'h9ABC_DEF0);
    next_cyc();
    instrE = I_MTLO; aluA = 32'hDEAD_BEEF; flushE = 1'b1;
    next_cyc();
    idle_in();
    #2;
    chk("flushed mtlo LO", LO, 32'h9ABC_DEF0);

    // Flush a divide at RUN cycle 10
    next_cyc();
    instrE = I_DIVU; aluA = 32'h64; aluB = 32'h7; validE = 1'b1;
    for (int i = 0; i < 10; i++) next_cyc();
    flushE = 1'b1;
    #2;
    chk("flush stall drops", {31'h0, stall_o}, 32'h0);
    chk("flush busy before edge", {31'h0, busy_o}, 32'h1);
    next_cyc();
    idle_in();
    #2;
    chk("flush busy after", {31'h0, busy_o}, 32'h0);
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      next_cyc();
      if (busy_o) seen_busy = 1;
    end
    chk("flush no restart", 32'(seen_busy), 32'd0);
    chk("flush HI kept", HI, 32'h1234_5678);
    chk("flush LO kept", LO, 32'h9ABC_DEF0);

    // External hold keeps the multiply in EX for 5 cycles after FIX
    issue_count(I_MULT, 32'h6, 32'h7, n);
    chk("hold stall cycles", 32'(n), 32'd33);
    holdE = 1'b1;
    seen_busy = 0;
    seen_stall = 0;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      #2;
      if (busy_o) seen_busy = 1;
      if (stall_o) seen_stall = 1;
    end
    chk("hold no reissue busy", 32'(seen_busy), 32'd0);
    chk("hold no reissue stall", 32'(seen_stall), 32'd0);
    chk("hold HI", HI, 32'h0);
    chk("hold LO", LO, 32'h0000_002A);
    next_cyc();
    idle_in();

    // Asynchronous reset in the middle of RUN
    next_cyc();
    instrE = I_MULT; aluA = 32'h7; aluB = 32'h9; validE = 1'b1;
    for (int i = 0; i < 5; i++) next_cyc();
    #2;
    chk("pre-reset busy", {31'h0, busy_o}, 32'h1);
    rst_n = 1'b0;
    validE = 1'b0;
    #1;
    chk("async reset HI", HI, 32'h0);
    chk("async reset LO", LO, 32'h0);
    chk("async reset busy", {31'h0, busy_o}, 32'h0);
    chk("async reset stall", {31'h0, stall_o}, 32'h0);
    next_cyc();
    rst_n = 1'b1;
    idle_in();
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
